// File: rtl/cpu_dma_tx_watchdog_if.sv
// Signal bundle between the CPU DMA TX path and its progress watchdog.
// master: the TX path / queue side (drives packet events, consumes timeout/flush).
// slave:  the watchdog itself.
// Signals:
//   watchdog_en    1 = watchdog armed
//   tx_pkt_start   first word of a packet accepted this cycle
//   tx_word_vld    any packet word accepted this cycle
//   tx_pkt_eop     last word of a packet accepted this cycle (implies tx_word_vld)
//   tx_stall       downstream back-pressure
//   tx_flush_done  TX queue finished discarding the partial packet
//   tx_timeout     one-cycle pulse per timeout event
//   tx_flush       level, queue discards the partial packet while high
//   tx_in_pkt      packet open
//   wd_state       debug state: 0 idle, 1 active, 2 flush
interface cpu_dma_tx_watchdog_if;
  logic       watchdog_en;
  logic       tx_pkt_start;
  logic       tx_word_vld;
  logic       tx_pkt_eop;
  logic       tx_stall;
  logic       tx_flush_done;
  logic       tx_timeout;
  logic       tx_flush;
  logic       tx_in_pkt;
  logic [1:0] wd_state;

  modport master (
    output watchdog_en, tx_pkt_start, tx_word_vld, tx_pkt_eop, tx_stall, tx_flush_done,
    input  tx_timeout, tx_flush, tx_in_pkt, wd_state
  );

  modport slave (
    input  watchdog_en, tx_pkt_start, tx_word_vld, tx_pkt_eop, tx_stall, tx_flush_done,
    output tx_timeout, tx_flush, tx_in_pkt, wd_state
  );
endinterface

// File: rtl/cpu_dma_tx_watchdog.sv
// Progress watchdog for the CPU DMA queue TX path. Tracks each open packet; if no word is
// accepted for TX_WATCHDOG_TIMEOUT cycles mid-packet it pulses tx_timeout for one cycle and
// holds tx_flush until the queue reports tx_flush_done.
// Ports:
//   clk      single clock
//   reset_n  asynchronous active-low reset
//   wd       cpu_dma_tx_watchdog_if.slave (packet events in; timeout/flush/status out)
// Optional feature macro: CPU_DMA_TX_WATCHDOG_STALL_EN
//   defined:   a no-progress cycle with tx_stall high holds the idle counter.
//   undefined: tx_stall is ignored.
module cpu_dma_tx_watchdog #(
  parameter int unsigned TX_WATCHDOG_TIMEOUT = 125000
) (
  input logic                   clk,
  input logic                   reset_n,
  cpu_dma_tx_watchdog_if.slave  wd
);

  localparam int unsigned CNT_WIDTH =
    (TX_WATCHDOG_TIMEOUT > 1) ? $clog2(TX_WATCHDOG_TIMEOUT) : 1;
  localparam logic [CNT_WIDTH-1:0] CntLast = CNT_WIDTH'(TX_WATCHDOG_TIMEOUT - 1);

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StActive = 2'd1,
    StFlush  = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 timeout_q, timeout_d;
  logic                 progress;
  logic                 hold;

  assign progress = wd.tx_pkt_start | wd.tx_word_vld | wd.tx_pkt_eop;

`ifdef CPU_DMA_TX_WATCHDOG_STALL_EN
  // Back-pressure from the MAC is not a DMA hang: freeze the counter.
  assign hold = wd.tx_stall & ~progress;
`else
  logic unused_tx_stall;
  assign unused_tx_stall = wd.tx_stall;
  assign hold            = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    timeout_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        // Single-word packets never open a packet.
        if (wd.watchdog_en && wd.tx_pkt_start && !wd.tx_pkt_eop) begin
          state_d = StActive;
          cnt_d   = '0;
        end
      end
      StActive: begin
        if (wd.tx_pkt_eop || !wd.watchdog_en) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else if (progress) begin
          cnt_d = '0;
        end else if (hold) begin
          cnt_d = cnt_q;
        end else if (cnt_q == CntLast) begin
          // Counter never passes CntLast, so it cannot wrap.
          state_d   = StFlush;
          cnt_d     = '0;
          timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StFlush: begin
        // Everything except flush_done is ignored; a started flush always completes.
        if (wd.tx_flush_done) begin
          state_d = StIdle;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign wd.tx_timeout = timeout_q;
  assign wd.tx_flush   = (state_q == StFlush);
  assign wd.tx_in_pkt  = (state_q == StActive);
  assign wd.wd_state   = state_q;

endmodule

// File: tb/tb_cpu_dma_tx_watchdog.sv
// Directed bench for cpu_dma_tx_watchdog with TX_WATCHDOG_TIMEOUT = 16.
// Cycle c: inputs driven for cycle c are sampled at the edge ending cycle c; outputs observed
// in cycle c reflect the registers loaded at the edge ending cycle c-1. Start is always cycle 0.
module tb_cpu_dma_tx_watchdog;

  localparam int unsigned T = 16;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  cpu_dma_tx_watchdog_if wd_if ();

  cpu_dma_tx_watchdog #(
    .TX_WATCHDOG_TIMEOUT(T)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .wd      (wd_if)
  );

  int n_vec = 0;
  int n_err = 0;

  logic [1:0] st_h [256];
  logic       fl_h [256];
  logic       ip_h [256];
  int         to_cnt;
  int         to_first;

  task automatic check_eq(input string tag, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    wd_if.watchdog_en   = 1'b1;
    wd_if.tx_pkt_start  = 1'b0;
    wd_if.tx_word_vld   = 1'b0;
    wd_if.tx_pkt_eop    = 1'b0;
    wd_if.tx_stall      = 1'b0;
    wd_if.tx_flush_done = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  // Start at cycle 0; other events at the given cycle (-1 = never). Stall high in 1..stall_hi.
  task automatic run(input int word_c, input int eop_c, input int en_off_c, input int stall_hi,
                     input int done_c, input int ncyc);
    to_cnt   = 0;
    to_first = -1;
    for (int c = 0; c < ncyc; c++) begin
      wd_if.tx_pkt_start  = (c == 0);
      wd_if.tx_pkt_eop    = (c == eop_c);
      wd_if.tx_word_vld   = (c == 0) || (c == word_c) || (c == eop_c);
      wd_if.watchdog_en   = !(en_off_c >= 0 && c >= en_off_c);
      wd_if.tx_stall      = (c >= 1 && c <= stall_hi);
      wd_if.tx_flush_done = (c == done_c);
      st_h[c] = wd_if.wd_state;
      fl_h[c] = wd_if.tx_flush;
      ip_h[c] = wd_if.tx_in_pkt;
      if (wd_if.tx_timeout) begin
        to_cnt++;
        if (to_first < 0) to_first = c;
      end
      tick();
    end
    idle_inputs();
  endtask

  int stall_exp;
  int post_pulses;

  initial begin
    reset_n = 1'b1;
    idle_inputs();
    do_reset();

    check_eq("rst_state", int'(wd_if.wd_state), 0);
    check_eq("rst_flush", int'(wd_if.tx_flush), 0);
    check_eq("rst_timeout", int'(wd_if.tx_timeout), 0);
    check_eq("rst_in_pkt", int'(wd_if.tx_in_pkt), 0);

    // Lone start, flush_done at 20.
    run(-1, -1, -1, 0, 20, 25);
    check_eq("t1_pulses", to_cnt, 1);
    check_eq("t1_pulse_cyc", to_first, 17);
    check_eq("t1_flush16", int'(fl_h[16]), 0);
    check_eq("t1_flush17", int'(fl_h[17]), 1);
    check_eq("t1_state17", int'(st_h[17]), 2);
    check_eq("t1_flush20", int'(fl_h[20]), 1);
    check_eq("t1_flush21", int'(fl_h[21]), 0);
    check_eq("t1_state21", int'(st_h[21]), 0);

    do_reset();
    run(10, 25, -1, 0, -1, 40);
    check_eq("t2_pulses", to_cnt, 0);
    check_eq("t2_inpkt0", int'(ip_h[0]), 0);
    check_eq("t2_inpkt1", int'(ip_h[1]), 1);
    check_eq("t2_inpkt25", int'(ip_h[25]), 1);
    check_eq("t2_inpkt26", int'(ip_h[26]), 0);

    do_reset();
    run(10, -1, -1, 0, 30, 35);
    check_eq("t2b_pulses", to_cnt, 1);
    check_eq("t2b_pulse_cyc", to_first, 27);

    do_reset();
    run(-1, 16, -1, 0, -1, 30);
    check_eq("t3_pulses", to_cnt, 0);
    check_eq("t3_state16", int'(st_h[16]), 1);
    check_eq("t3_state17", int'(st_h[17]), 0);

    do_reset();
    run(-1, 0, -1, 0, -1, 10);
    check_eq("t3b_state1", int'(st_h[1]), 0);
    check_eq("t3b_pulses", to_cnt, 0);

    // Progress on the terminal-count cycle wins.
    do_reset();
    run(16, -1, -1, 0, -1, 40);
    check_eq("term_pulses", to_cnt, 1);
    check_eq("term_pulse_cyc", to_first, 33);

    // flush_done on the transition cycle is ignored; on the first FLUSH cycle it is taken.
    do_reset();
    run(-1, -1, -1, 0, 16, 20);
    check_eq("done16_state18", int'(st_h[18]), 2);
    check_eq("done16_state19", int'(st_h[19]), 2);
    do_reset();
    run(-1, -1, -1, 0, 17, 20);
    check_eq("done17_state17", int'(st_h[17]), 2);
    check_eq("done17_state18", int'(st_h[18]), 0);
    check_eq("done17_flush18", int'(fl_h[18]), 0);

    do_reset();
    run(-1, -1, 8, 0, -1, 40);
    check_eq("t4_state8", int'(st_h[8]), 1);
    check_eq("t4_state9", int'(st_h[9]), 0);
    check_eq("t4_pulses", to_cnt, 0);

    // Asynchronous reset in the middle of FLUSH.
    do_reset();
    run(-1, -1, -1, 0, -1, 19);
    check_eq("t4b_flush_before", int'(wd_if.tx_flush), 1);
    #2;
    reset_n = 1'b0;
    #1;
    check_eq("t4b_flush_async", int'(wd_if.tx_flush), 0);
    check_eq("t4b_state_async", int'(wd_if.wd_state), 0);
    tick();
    reset_n = 1'b1;
    post_pulses = 0;
    for (int c = 0; c < 30; c++) begin
      if (wd_if.tx_timeout) post_pulses++;
      tick();
    end
    check_eq("t4b_post_pulses", post_pulses, 0);
    check_eq("t4b_post_state", int'(wd_if.wd_state), 0);

`ifdef CPU_DMA_TX_WATCHDOG_STALL_EN
    stall_exp = 117;
`else
    stall_exp = 17;
`endif
    do_reset();
    run(-1, -1, -1, 100, -1, 130);
    check_eq("t5_pulses", to_cnt, 1);
    check_eq("t5_pulse_cyc", to_first, stall_exp);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
